keypad_events: RTL and testbench

Parametrised successor to the single-key release detector in the CPU. It debounces an N-key keypad matrix on a sample strobe, turns each settled key change into a press or release event, and queues events in a show-ahead FIFO with a valid/ready handshake. The CPU drains the FIFO for Fx0A waits. It reads `stable_keys` directly for Ex9E and ExA1 tests.

---
 rtl/keypad_events.sv | 152 +++++++++++++++
 tb/tb_keypad_events.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_events.sv
// Debounces an N-key keypad, turns settled changes into press/release events and queues them in a show-ahead FIFO.
// Optional feature macro KEYPAD_RELEASE_EVENTS_EN: when defined, releases are queued as well as presses.
module keypad_events #(
    parameter int NUM_KEYS   = 16,
    parameter int IDX_W      = $clog2(NUM_KEYS),
    parameter int DEBOUNCE   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sample_en,
    input  logic [NUM_KEYS-1:0]               keypad_matrix,
    output logic [NUM_KEYS-1:0]               stable_keys,
    output logic                              any_down,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [IDX_W-1:0]                  evt_index,
    output logic                              evt_press,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   evt_fill
);

    localparam int                    PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                    FILL_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0]            DB_LAST    = 4'(DEBOUNCE - 1);
    localparam logic [FILL_W-1:0]     DEPTH_FILL = FILL_W'(FIFO_DEPTH);
    localparam logic [NUM_KEYS-1:0]   ONE_KEY    = NUM_KEYS'(1);

    logic [NUM_KEYS-1:0][3:0] cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]      stable_q, stable_d;
    logic [NUM_KEYS-1:0]      pend_q, pend_d;
    logic [NUM_KEYS-1:0]      tog_s;
    logic [NUM_KEYS-1:0]      clr_mask_s;
    logic [IDX_W-1:0]         push_idx_s;
    logic                     push_s;
    logic                     pop_s;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic                     evt_valid_q;
    logic                     any_down_q;
    logic [IDX_W-1:0]         idx_mem_q [FIFO_DEPTH];
`ifdef KEYPAD_RELEASE_EVENTS_EN
    logic                     dir_mem_q [FIFO_DEPTH];
`endif

    // Per-key debounce: count consecutive disagreeing samples, toggle the stable level on the last one.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        tog_s    = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (sample_en) begin
                if (keypad_matrix[k] == stable_q[k]) begin
                    cnt_d[k] = 4'd0;
                end else if (cnt_q[k] == DB_LAST) begin
                    cnt_d[k]    = 4'd0;
                    stable_d[k] = ~stable_q[k];
                    tog_s[k]    = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 4'd1;
                end
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // Scanner: lowest pending index is pushed whenever the registered fill leaves room.
    always_comb begin
        push_idx_s = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                push_idx_s = IDX_W'(k);
            end else begin
                push_idx_s = push_idx_s;
            end
        end
        push_s     = (pend_q != '0) && (fill_q < DEPTH_FILL);
        clr_mask_s = push_s ? (ONE_KEY << push_idx_s) : '0;
    end

    // Pending update: scanner clear and a same-cycle toggle combine by XOR so no change is lost.
    always_comb begin
`ifdef KEYPAD_RELEASE_EVENTS_EN
        pend_d = pend_q ^ clr_mask_s ^ tog_s;
`else
        // A release cancels any un-queued press and never arms an event of its own.
        pend_d = (pend_q ^ clr_mask_s ^ (tog_s & ~stable_q)) & ~(tog_s & stable_q);
`endif
    end

    // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth.
    always_comb begin
        pop_s    = (fill_q != '0) && evt_ready;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        if (push_s && !pop_s) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (pop_s && !push_s) begin
            fill_d = fill_q - FILL_W'(1);
        end else begin
            fill_d = fill_q;
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            stable_q    <= '0;
            pend_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            evt_valid_q <= 1'b0;
            any_down_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            evt_valid_q <= (fill_d != '0);
            any_down_q  <= |stable_d;
        end
    end

    // Event storage; contents are don't-care while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            idx_mem_q[wr_ptr_q] <= push_idx_s;
`ifdef KEYPAD_RELEASE_EVENTS_EN
            dir_mem_q[wr_ptr_q] <= stable_q[push_idx_s];
`endif
        end else begin
            idx_mem_q[wr_ptr_q] <= idx_mem_q[wr_ptr_q];
        end
    end

    assign stable_keys = stable_q;
    assign any_down    = any_down_q;
    assign evt_valid   = evt_valid_q;
    assign evt_fill    = fill_q;
    assign evt_index   = idx_mem_q[rd_ptr_q];
`ifdef KEYPAD_RELEASE_EVENTS_EN
    assign evt_press   = dir_mem_q[rd_ptr_q];
`else
    assign evt_press   = 1'b1;
`endif

endmodule

// File: tb/tb_keypad_events.sv
// Self-checking bench for keypad_events: directed test-plan steps followed by random traffic against a queue-based model.
module tb_keypad_events;

    localparam int NK = 16;
    localparam int DB = 2;
    localparam int FD = 8;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_en = 1'b0;
    logic          evt_ready = 1'b0;
    logic [NK-1:0] keypad_matrix = '0;
    logic [NK-1:0] stable_keys;
    logic          any_down;
    logic          evt_valid;
    logic [3:0]    evt_index;
    logic          evt_press;
    logic [3:0]    evt_fill;

    keypad_events #(.NUM_KEYS(NK), .DEBOUNCE(DB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .keypad_matrix(keypad_matrix),
        .stable_keys(stable_keys), .any_down(any_down), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_index(evt_index), .evt_press(evt_press), .evt_fill(evt_fill)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] idx; logic press; } evt_t;

    int            checks = 0;
    int            errors = 0;
    logic [NK-1:0] keys = '0;
    evt_t          m_q[$];
    logic [NK-1:0] m_stable = '0;
    logic [NK-1:0] m_pend = '0;
    int            m_run[NK];
    int            popped[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: each key counts a run of disagreeing samples; a run of DB flips the key and records a change.
    task automatic model_update(input bit rst, input bit se, input bit rdy, input logic [NK-1:0] raw);
        int pre;
        int k;
        logic [NK-1:0] clr;
        logic [NK-1:0] tg;
        logic [NK-1:0] nst;
        logic p;
        if (rst) begin
            m_stable = '0;
            m_pend   = '0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
            m_q.delete();
            return;
        end
        pre = m_q.size();
        clr = '0;
        tg  = '0;
        nst = m_stable;
        if (pre > 0 && rdy) void'(m_q.pop_front());
        if (m_pend != '0 && pre < FD) begin
            k = 0;
            while (!m_pend[k]) k++;
            m_q.push_back({8'(k), m_stable[k]});
            clr[k] = 1'b1;
        end
        if (se) begin
            for (int i = 0; i < NK; i++) begin
                if (raw[i] == m_stable[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] >= DB) begin
                        m_run[i] = 0;
                        nst[i]   = ~nst[i];
                        tg[i]    = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < NK; i++) begin
            p = m_pend[i] ^ clr[i];
            if (tg[i]) begin
                if (REL_EN || nst[i]) p = ~p;
                else p = 1'b0;
            end
            m_pend[i] = p;
        end
        m_stable = nst;
    endtask

    task automatic step(input bit rst, input bit se, input bit rdy);
        reset         = rst;
        sample_en     = se;
        evt_ready     = rdy;
        keypad_matrix = keys;
        if (!rst && rdy && evt_valid) popped.push_back(int'(evt_index));
        @(posedge clk);
        model_update(rst, se, rdy, keys);
        #1;
        chk("stable_keys", 64'(stable_keys), 64'(m_stable));
        chk("any_down", 64'(any_down), 64'(|m_stable));
        chk("evt_valid", 64'(evt_valid), 64'(m_q.size() != 0));
        chk("evt_fill", 64'(evt_fill), 64'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("evt_index", 64'(evt_index), 64'(m_q[0].idx));
            chk("evt_press", 64'(evt_press), 64'(m_q[0].press));
        end
    endtask

    task automatic tick(input bit rdy);
        step(1'b0, 1'b1, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, rdy);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) idle(1'b1);
    endtask

    initial begin
        int cnt7;

        // Reset state
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rst_stable", 64'(stable_keys), 64'h0);
        chk("rst_valid", 64'(evt_valid), 64'h0);
        chk("rst_fill", 64'(evt_fill), 64'h0);
        chk("rst_any", 64'(any_down), 64'h0);

        // Debounce latency on key 5
        keys[5] = 1'b1;
        tick(1'b0);
        chk("t1_first_tick", 64'(stable_keys[5]), 64'h0);
        tick(1'b0);
        chk("t1_stable5", 64'(stable_keys[5]), 64'h1);
        chk("t1_valid_e0", 64'(evt_valid), 64'h0);
        idle(1'b0);
        chk("t1_valid", 64'(evt_valid), 64'h1);
        chk("t1_index", 64'(evt_index), 64'h5);
        chk("t1_press", 64'(evt_press), 64'h1);
        idle(1'b1);
        chk("t1_popped", 64'(evt_fill), 64'h0);
        keys[5] = 1'b0;
        tick(1'b0);
        tick(1'b0);
        idle(1'b0);
        chk("t1_rel_valid", 64'(evt_valid), 64'(REL_EN));
        if (evt_valid) begin
            chk("t1_rel_index", 64'(evt_index), 64'h5);
            chk("t1_rel_press", 64'(evt_press), 64'h0);
        end
        drain(2);

        // Bounce rejection on key 3
        for (int i = 0; i < 10; i++) begin
            keys[3] = (i % 2 == 0);
            tick(1'b0);
        end
        keys[3] = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        chk("t2_stable", 64'(stable_keys), 64'h0);
        chk("t2_fill", 64'(evt_fill), 64'h0);

        // Simultaneous keys 9, 2, 14
        keys = 16'h4204;
        tick(1'b0);
        tick(1'b0);
        for (int i = 1; i <= 3; i++) begin
            idle(1'b0);
            chk("t3_fill", 64'(evt_fill), 64'(i));
        end
        chk("t3_head0", 64'(evt_index), 64'd2);
        idle(1'b1);
        chk("t3_head1", 64'(evt_index), 64'd9);
        idle(1'b1);
        chk("t3_head2", 64'(evt_index), 64'd14);
        idle(1'b1);
        keys = '0;
        tick(1'b0);
        tick(1'b0);
        drain(5);

        // Full back-pressure with keys 0..9
        popped.delete();
        keys = 16'h03FF;
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("t4_full", 64'(evt_fill), 64'd8);
        idle(1'b1);
        chk("t4_no_push", 64'(evt_fill), 64'd7);
        idle(1'b0);
        chk("t4_late_push", 64'(evt_fill), 64'd8);
        drain(12);
        chk("t4_count", 64'(popped.size()), 64'd10);
        for (int i = 0; i < popped.size(); i++) chk("t4_order", 64'(popped[i]), 64'(i));
        keys = '0;
        tick(1'b0);
        tick(1'b0);
        drain(14);

        // Cancelled pending change on key 7 while full
        popped.delete();
        keys = 16'hFF00;
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 9; i++) idle(1'b0);
        chk("t5_full", 64'(evt_fill), 64'd8);
        keys[7] = 1'b1;
        tick(1'b0);
        tick(1'b0);
        idle(1'b0);
        keys[7] = 1'b0;
        tick(1'b0);
        tick(1'b0);
        drain(10);
        cnt7 = 0;
        foreach (popped[i]) if (popped[i] == 7) cnt7++;
        chk("t5_no_key7", 64'(cnt7), 64'd0);
        chk("t5_count", 64'(popped.size()), 64'd8);
        keys = '0;
        tick(1'b0);
        tick(1'b0);
        drain(12);

        // Reset mid-stream with keys 1 and 4 held
        keys = 16'h3C00;
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        chk("t6_fill4", 64'(evt_fill), 64'd4);
        keys = 16'h0012;
        step(1'b1, 1'b0, 1'b0);
        chk("t6_valid", 64'(evt_valid), 64'h0);
        chk("t6_fill", 64'(evt_fill), 64'h0);
        chk("t6_stable", 64'(stable_keys), 64'h0);
        tick(1'b0);
        tick(1'b0);
        chk("t6_stable_after", 64'(stable_keys), 64'h0012);
        idle(1'b0);
        chk("t6_first", 64'(evt_index), 64'd1);
        chk("t6_first_press", 64'(evt_press), 64'h1);
        idle(1'b1);
        chk("t6_second", 64'(evt_index), 64'd4);
        keys = '0;
        tick(1'b0);
        tick(1'b0);
        drain(6);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
            step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        end
        drain(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
